ring_osc_meter_ctrl: RTL and testbench
======================================

Name: ring_osc_meter_ctrl

Overview:
- Sequences a gated ring oscillator to measure its frequency against the system clock.
- On request, asserts the oscillator enable and waits a settle period. It then counts oscillator edges over a programmable window of clk cycles, disables the oscillator and reports the edge count.
- The oscillator-domain edge counter sits outside this block and delivers a Gray-coded count. This block synchronizes that count and takes the difference between two snapshots.

Parameters:
- CNT_W, 16, width of the Gray-coded oscillator count and of the result.
- GATE_W, 24, width of the gate-window length in clk cycles.
- SETTLE_CYCLES, 16, clk cycles between enable assertion and the start snapshot (minimum 1).
- SYNC_STAGES, 2, flip-flop stages in the osc_count_gray synchronizer (minimum 2).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  measurement request; sampled only in IDLE.
- abort  in  1  cancel the measurement in progress.
- gate_cycles  in  GATE_W  window length; latched on accepted start.
- osc_count_gray  in  CNT_W  Gray-coded oscillator edge count, asynchronous to clk.
- osc_enable  out  1  oscillator enable.
- busy  out  1  high from the cycle after start acceptance until done or abort.
- done  out  1  one-cycle pulse; result and err are valid with it.
- result  out  CNT_W  edges counted in the window, modulo 2^CNT_W.
- err  out  1  set with done when gate_cycles == 0.

Behaviour:
- Reset (async assert, sync release): state IDLE. osc_enable=0, busy=0, done=0, result=0, err=0, all synchronizer flops 0.
- Synchronizer:
  - osc_count_gray passes through SYNC_STAGES flops.
  - The synchronized value is converted Gray-to-binary combinationally, giving cnt_bin.
  - Both snapshots see the same delay, so the delay cancels in the difference.
- States and transitions:
  - IDLE: start=1 latches gate_cycles into gate_r.
    - If gate_cycles == 0, go to FINISH with err_next=1; osc_enable stays 0.
    - Otherwise go to SETTLE with osc_enable=1, busy=1 from the next cycle, settle counter = SETTLE_CYCLES-1.
  - SETTLE: decrement the settle counter. At 0, register start_snap <= cnt_bin and go to GATE with gate counter = gate_r-1.
  - GATE: decrement the gate counter each cycle.
    - At 0, register end_snap <= cnt_bin and go to FINISH.
    - The window therefore spans exactly gate_r cycles between the two snapshots.
  - FINISH (one cycle): result <= end_snap - start_snap (CNT_W-bit wrap subtraction), err <= err_next, osc_enable <= 0, busy <= 0, done <= 1. Then go to IDLE.
- Output timing:
  - done is high for exactly one cycle.
  - result and err hold their values until the next done.
  - A gate==0 request gives result=0 and err=1.
- start while busy: ignored, not queued.
- abort:
  - In SETTLE or GATE, the next cycle has state IDLE, osc_enable=0, busy=0.
  - No done pulse; result and err keep their previous values.
  - abort has priority over a simultaneous GATE completion.
  - abort in IDLE or FINISH has no effect.
- Simultaneous start and abort in IDLE: start wins.
- Reset mid-measurement: osc_enable drops immediately (asynchronously); there is no done.
- Wrap-around: a count that crosses 2^CNT_W during the window gives the correct modulo difference. A window with ≥2^CNT_W edges aliases silently; sizing gate_cycles to prevent this is the software's responsibility.

Test Plan:
- Bench model: oscillator count increments by 3 per clk while osc_enable=1, Gray-encoded. SETTLE_CYCLES=16, gate_cycles=100, start pulse → osc_enable high 1+16+100 cycles, done once, result=300, err=0.
- Wrap: preset the model count to 0xFFF0, increment 1 per clk, gate_cycles=40 → result=40 (0x0028), err=0.
- gate_cycles=0, start → done on the second cycle after start, result=0, err=1, osc_enable never asserted.
- abort asserted at gate cycle 50 of 100 → osc_enable=0 and busy=0 next cycle, no done, result keeps its previous value (300). A fresh start afterwards measures correctly.
- rst_n pulsed low during GATE → osc_enable=0 asynchronously, all outputs 0, state IDLE. After release, a start with gate_cycles=10 at 2/clk gives result=20.
- start re-pulsed every cycle while busy → exactly one done per accepted start. Back-to-back: start in the cycle after done is accepted.

Source files
------------

// File: rtl/ring_osc_meter_ctrl.sv
// ring_osc_meter_ctrl
//
// Measures a gated ring oscillator against the system clock. On an accepted
// start the oscillator is enabled and allowed to settle. Two snapshots of the
// oscillator's edge count are then taken gate_cycles clk cycles apart. The
// oscillator is switched off and the difference between the snapshots is
// reported with a one-cycle done pulse.
//
// The oscillator-domain edge counter lives outside this block and delivers a
// Gray-coded count. Only one bit of a Gray count changes per step, so a
// multi-flop synchronizer always resolves to either the old or the new value.
// Both snapshots pass through the same synchronizer, so its latency cancels
// in the difference.
//
// Handshake: start is a level that is sampled only while the FSM is idle.
// Starts that arrive at any other time are dropped, not queued. abort cancels
// a measurement in the settle or gate phase. In that case there is no done
// pulse and result/err keep their previous values. done is a single-cycle
// strobe, and result/err are valid in that cycle and hold until the next done.
//
// Ports:
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   start          measurement request (sampled in IDLE only)
//   abort          cancel the measurement in progress
//   gate_cycles    window length in clk cycles, latched on accepted start
//   osc_count_gray Gray-coded oscillator edge count (asynchronous to clk)
//   osc_enable     oscillator enable
//   busy           measurement in progress
//   done           one-cycle completion pulse
//   result         edges counted in the window, modulo 2^CNT_W
//   err            set with done when the requested window was zero
module ring_osc_meter_ctrl #(
    parameter int CNT_W         = 16,
    parameter int GATE_W        = 24,
    parameter int SETTLE_CYCLES = 16,
    parameter int SYNC_STAGES   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [GATE_W-1:0] gate_cycles,
    input  logic [CNT_W-1:0]  osc_count_gray,
    output logic              osc_enable,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  result,
    output logic              err
);

    localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_GATE   = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [SET_W-1:0]   settle_cnt_q, settle_cnt_d;
    logic [GATE_W-1:0]  gate_len_q, gate_len_d;
    logic [GATE_W-1:0]  gate_cnt_q, gate_cnt_d;
    logic [CNT_W-1:0]   start_snap_q, start_snap_d;
    logic [CNT_W-1:0]   end_snap_q, end_snap_d;
    logic               err_next_q, err_next_d;
    logic               osc_enable_q, osc_enable_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [CNT_W-1:0]   result_q, result_d;
    logic               err_q, err_d;

    // Synchronizer chain for the Gray count.
    logic [CNT_W-1:0]   sync_q [SYNC_STAGES];
    logic [CNT_W-1:0]   gray_sync;
    logic [CNT_W-1:0]   cnt_bin;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= osc_count_gray;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign gray_sync = sync_q[SYNC_STAGES-1];

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        cnt_bin = '0;
        for (int i = 0; i < CNT_W; i++) begin
            cnt_bin[i] = ^(gray_sync >> i);
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            settle_cnt_q <= '0;
            gate_len_q   <= '0;
            gate_cnt_q   <= '0;
            start_snap_q <= '0;
            end_snap_q   <= '0;
            err_next_q   <= 1'b0;
            osc_enable_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            result_q     <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            gate_len_q   <= gate_len_d;
            gate_cnt_q   <= gate_cnt_d;
            start_snap_q <= start_snap_d;
            end_snap_q   <= end_snap_d;
            err_next_q   <= err_next_d;
            osc_enable_q <= osc_enable_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            result_q     <= result_d;
            err_q        <= err_d;
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        gate_len_d   = gate_len_q;
        gate_cnt_d   = gate_cnt_q;
        start_snap_d = start_snap_q;
        end_snap_d   = end_snap_q;
        err_next_d   = err_next_q;
        osc_enable_d = osc_enable_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        result_d     = result_q;
        err_d        = err_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    gate_len_d = gate_cycles;
                    if (gate_cycles == '0) begin
                        // An empty window is reported as an error without
                        // waking the oscillator.
                        err_next_d = 1'b1;
                        state_d    = ST_FINISH;
                    end else begin
                        err_next_d   = 1'b0;
                        osc_enable_d = 1'b1;
                        busy_d       = 1'b1;
                        settle_cnt_d = SET_W'(SETTLE_CYCLES - 1);
                        state_d      = ST_SETTLE;
                    end
                end
            end

            ST_SETTLE: begin
                if (abort) begin
                    osc_enable_d = 1'b0;
                    busy_d       = 1'b0;
                    state_d      = ST_IDLE;
                end else if (settle_cnt_q == '0) begin
                    start_snap_d = cnt_bin;
                    gate_cnt_d   = gate_len_q - 1'b1;
                    state_d      = ST_GATE;
                end else begin
                    settle_cnt_d = settle_cnt_q - 1'b1;
                end
            end

            ST_GATE: begin
                // abort wins over a window that completes in the same cycle.
                if (abort) begin
                    osc_enable_d = 1'b0;
                    busy_d       = 1'b0;
                    state_d      = ST_IDLE;
                end else if (gate_cnt_q == '0) begin
                    end_snap_d = cnt_bin;
                    state_d    = ST_FINISH;
                end else begin
                    gate_cnt_d = gate_cnt_q - 1'b1;
                end
            end

            ST_FINISH: begin
                // The subtraction wraps, so a count that rolls over during
                // the window still yields the correct modulo difference.
                result_d     = err_next_q ? '0 : (end_snap_q - start_snap_q);
                err_d        = err_next_q;
                osc_enable_d = 1'b0;
                busy_d       = 1'b0;
                done_d       = 1'b1;
                state_d      = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign osc_enable = osc_enable_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign result     = result_q;
    assign err        = err_q;

endmodule

// File: tb/tb_ring_osc_meter_ctrl.sv
// Testbench for ring_osc_meter_ctrl.
// The oscillator model advances a binary count by osc_step on every falling
// clk edge while osc_enable is high. It presents that count Gray-coded. The
// reference result of a measurement is simply step * gate_cycles, modulo
// 2^16, with err set only for an empty window.
module tb_ring_osc_meter_ctrl;

    localparam int CNT_W  = 16;
    localparam int GATE_W = 24;
    localparam int SETTLE = 16;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic              abort;
    logic [GATE_W-1:0] gate_cycles;
    logic [CNT_W-1:0]  osc_count_gray;
    logic              osc_enable;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  result;
    logic              err;

    logic [CNT_W-1:0]  osc_bin;
    int                osc_step;

    int checks;
    int errors;
    int done_cnt;
    int en_cnt;
    int busy_rise;
    logic busy_prev;

    logic [CNT_W-1:0] last_result;
    logic             last_err;

    ring_osc_meter_ctrl #(
        .CNT_W(CNT_W),
        .GATE_W(GATE_W),
        .SETTLE_CYCLES(SETTLE),
        .SYNC_STAGES(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .abort(abort),
        .gate_cycles(gate_cycles),
        .osc_count_gray(osc_count_gray),
        .osc_enable(osc_enable),
        .busy(busy),
        .done(done),
        .result(result),
        .err(err)
    );

    // Clock and reset.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Oscillator model.
    assign osc_count_gray = osc_bin ^ (osc_bin >> 1);

    always @(negedge clk) begin
        if (osc_enable === 1'b1) osc_bin = osc_bin + CNT_W'(osc_step);
    end

    // Event monitor.
    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
        if (osc_enable === 1'b1) en_cnt++;
        if (busy === 1'b1 && busy_prev !== 1'b1) busy_rise++;
        busy_prev = busy;
    end

    // Reference model.
    function automatic logic [CNT_W-1:0] model_result(input int gate, input int step);
        longint prod;
        if (gate == 0) return '0;
        prod = longint'(gate) * longint'(step);
        return CNT_W'(prod % 65536);
    endfunction

    function automatic logic model_err(input int gate);
        return (gate == 0);
    endfunction

    // Driver tasks.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_counts();
        done_cnt  = 0;
        en_cnt    = 0;
        busy_rise = 0;
    endtask

    task automatic start_meas(input int gate, input int step, input logic [CNT_W-1:0] preset);
        osc_step    = step;
        osc_bin     = preset;
        gate_cycles = GATE_W'(gate);
        start       = 1'b1;
        tick();
        start       = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    // Runs one full measurement and checks its result against the model.
    task automatic measure_and_check(input string name, input int gate, input int step,
                                     input logic [CNT_W-1:0] preset);
        bit ok;
        logic [CNT_W-1:0] exp_r;
        logic exp_e;
        exp_r = model_result(gate, step);
        exp_e = model_err(gate);
        start_meas(gate, step, preset);
        wait_done(gate + SETTLE + 20, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s_timeout: done never seen (gate=%0d)", name, gate);
        end else begin
            checks++;
            if (result !== exp_r) begin
                errors++;
                $display("FAIL %s_result: got %0d expected %0d (gate=%0d step=%0d)",
                         name, result, exp_r, gate, step);
            end
            checks++;
            if (err !== exp_e) begin
                errors++;
                $display("FAIL %s_err: got %b expected %b", name, err, exp_e);
            end
            last_result = exp_r;
            last_err    = exp_e;
        end
        tick();
    endtask

    // Scenario tasks.
    task automatic test_reset();
        rst_n       = 1'b0;
        start       = 1'b0;
        abort       = 1'b0;
        gate_cycles = '0;
        osc_bin     = '0;
        osc_step    = 0;
        busy_prev   = 1'b0;
        clear_counts();
        repeat (3) @(posedge clk);
        #1;
        checks++; if (osc_enable !== 1'b0) begin errors++; $display("FAIL reset_osc_enable: got %b expected 0", osc_enable); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (result !== '0) begin errors++; $display("FAIL reset_result: got %0d expected 0", result); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        last_result = '0;
        last_err    = 1'b0;
    endtask

    task automatic test_basic();
        clear_counts();
        measure_and_check("basic", 100, 3, '0);
        repeat (3) tick();
        checks++;
        if (done_cnt !== 1) begin errors++; $display("FAIL basic_done_count: got %0d expected 1", done_cnt); end
        checks++;
        if (en_cnt !== 1 + SETTLE + 100) begin
            errors++;
            $display("FAIL basic_enable_cycles: got %0d expected %0d", en_cnt, 1 + SETTLE + 100);
        end
    endtask

    task automatic test_abort();
        bit ok;
        clear_counts();
        start_meas(100, 3, '0);
        repeat (SETTLE + 50) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (osc_enable !== 1'b0) begin errors++; $display("FAIL abort_osc_enable: got %b expected 0", osc_enable); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
        repeat (150) tick();
        checks++;
        if (done_cnt !== 0) begin errors++; $display("FAIL abort_no_done: got %0d dones expected 0", done_cnt); end
        checks++;
        if (result !== last_result) begin errors++; $display("FAIL abort_result_kept: got %0d expected %0d", result, last_result); end
        checks++;
        if (err !== last_err) begin errors++; $display("FAIL abort_err_kept: got %b expected %b", err, last_err); end
        ok = 1'b0;
        measure_and_check("after_abort", 60, 2, 16'h1234);
    endtask

    task automatic test_wrap();
        measure_and_check("wrap", 40, 1, 16'hFFF0);
    endtask

    task automatic test_gate_zero();
        clear_counts();
        start_meas(0, 3, '0);
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL zero_done_early: got %b expected 0", done); end
        tick();
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL zero_done_cycle2: got %b expected 1", done); end
        checks++;
        if (result !== '0) begin errors++; $display("FAIL zero_result: got %0d expected 0", result); end
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL zero_err: got %b expected 1", err); end
        tick();
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL zero_done_width: got %b expected 0", done); end
        tick();
        checks++;
        if (en_cnt !== 0) begin errors++; $display("FAIL zero_osc_enable: enabled %0d cycles expected 0", en_cnt); end
        last_result = '0;
        last_err    = 1'b1;
    endtask

    task automatic test_reset_mid();
        clear_counts();
        start_meas(100, 3, '0);
        repeat (SETTLE + 30) tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (osc_enable !== 1'b0) begin errors++; $display("FAIL rstmid_osc_enable: got %b expected 0", osc_enable); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
        checks++; if (result !== '0) begin errors++; $display("FAIL rstmid_result: got %0d expected 0", result); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rstmid_err: got %b expected 0", err); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++;
        if (done_cnt !== 0) begin errors++; $display("FAIL rstmid_no_done: got %0d dones expected 0", done_cnt); end
        last_result = '0;
        last_err    = 1'b0;
        measure_and_check("after_reset", 10, 2, '0);
    endtask

    task automatic test_back_to_back();
        int  seen;
        bit  check_next;
        clear_counts();
        osc_step    = 1;
        osc_bin     = 16'h0100;
        gate_cycles = GATE_W'(20);
        start       = 1'b1;
        seen        = 0;
        check_next  = 1'b0;
        for (int i = 0; i < 600 && seen < 3; i++) begin
            tick();
            if (check_next) begin
                check_next = 1'b0;
                checks++;
                if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept: busy got %b expected 1 after done", busy); end
            end
            if (done === 1'b1) begin
                seen++;
                check_next = 1'b1;
                checks++;
                if (result !== model_result(20, 1)) begin
                    errors++;
                    $display("FAIL b2b_result: got %0d expected %0d", result, model_result(20, 1));
                end
                checks++;
                if (err !== 1'b0) begin errors++; $display("FAIL b2b_err: got %b expected 0", err); end
            end
        end
        tick();
        start = 1'b0;
        checks++;
        if (seen != 3) begin errors++; $display("FAIL b2b_timeout: saw %0d dones expected 3", seen); end
        repeat (60) tick();
        checks++;
        if (done_cnt !== busy_rise) begin
            errors++;
            $display("FAIL b2b_one_done_per_start: got %0d dones for %0d accepted starts", done_cnt, busy_rise);
        end
        last_result = model_result(20, 1);
        last_err    = 1'b0;
    endtask

    task automatic test_random();
        int g;
        int s;
        logic [CNT_W-1:0] p;
        for (int n = 0; n < 8; n++) begin
            g = $urandom_range(300, 1);
            s = $urandom_range(7, 1);
            p = CNT_W'($urandom_range(65535, 0));
            measure_and_check("random", g, s, p);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_abort();
        test_wrap();
        test_gate_zero();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
